multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multicycle MIPS control FSM; successor to the single-cycle decoder. Sequences each instruction over 3-5 states.
//  Supports R-type, lw, sw, addi, beq, j, with a ready handshake to variable-latency memory.
//  Traps illegal opcodes instead of silently writing the register file.
//  Sits between the IR opcode field and the shared-memory multicycle datapath.
// PARAMETERS
//  OPCODE_W      6  opcode width (fixed encodings live in mips_pkg)
//  ALU_OP_W      2  alu_op width: 00 add, 01 sub, 10 use funct
//  MEM_HANDSHAKE 1  1: memory states wait on mem_ready; 0: mem_ready ignored (treated as 1)
//  ILLEGAL_TRAP  1  1: illegal opcode -> TRAP until reset; 0: illegal opcode -> FETCH (nop)
// PORTS
//  clk           in   1         clock; all state updates on rising edge
//  rst_n         in   1         synchronous active-low reset
//  opcode        in   OPCODE_W  IR[31:26]; valid from DECODE onward
//  mem_ready     in   1         memory completed this cycle's access
//  pc_write      out  1         unconditional PC load
//  branch        out  1         PC load if ALU zero
//  iord          out  1         0: address = PC; 1: address = ALUOut
//  mem_write     out  1         memory write strobe
//  ir_write      out  1         IR load
//  reg_dst       out  1         1: rd; 0: rt
//  mem_to_reg    out  1         1: MDR; 0: ALUOut
//  reg_write     out  1         register file write
//  alu_src_a     out  1         0: PC; 1: A
//  alu_src_b     out  2         00: B, 01: 4, 10: signext imm, 11: signext imm<<2
//  pc_src        out  2         00: ALU result, 01: ALUOut, 10: jump target
//  alu_op        out  ALU_OP_W  to alu_decoder
//  instr_done    out  1         one-cycle pulse on an instruction's final cycle
//  illegal_instr out  1         high while in TRAP
//  state_dbg     out  4         current state encoding
// BEHAVIOUR
//  Reset: while rst_n=0 (sampled), state<=FETCH; all outputs are forced 0 in that cycle.
//  Outputs are Moore, decoded from state. Unlisted outputs are 0 in each state. mem_ready gating is noted per state.
//  FETCH:    iord=0, src_a=0, src_b=01, alu_op=00, pc_src=00.
//            ir_write=pc_write=mem_ready; stay until mem_ready, then DECODE.
//  DECODE:   src_a=0, src_b=11, alu_op=00. Next state by opcode:
//            lw/sw->MEMADR, R(000000)->EXEC, addi->ADDIEX, beq->BRANCH, j->JUMP, other->TRAP|FETCH.
//  MEMADR:   src_a=1, src_b=10, alu_op=00. lw->MEMRD, sw->MEMWR.
//  MEMRD:    iord=1; stay until mem_ready, then MEMWB.
//  MEMWB:    reg_dst=0, mem_to_reg=1, reg_write=1, done. ->FETCH.
//  MEMWR:    iord=1, mem_write=1 held until mem_ready; done=mem_ready. ->FETCH on mem_ready.
//  EXEC:     src_a=1, src_b=00, alu_op=10. ->ALUWB.
//  ALUWB:    reg_dst=1, mem_to_reg=0, reg_write=1, done. ->FETCH.
//  ADDIEX:   src_a=1, src_b=10, alu_op=00. ->ADDIWB.
//  ADDIWB:   reg_dst=0, mem_to_reg=0, reg_write=1, done. ->FETCH.
//  BRANCH:   src_a=1, src_b=00, alu_op=01, pc_src=01, branch=1, done. ->FETCH.
//  JUMP:     pc_src=10, pc_write=1, done. ->FETCH.
//  TRAP:     illegal_instr=1, no write strobes; exits only via reset.
//  Latency with mem_ready=1: beq/j 3, R/addi/sw 4, lw 5 cycles. Each mem_ready=0 cycle adds one.
//  An opcode change outside DECODE/MEMADR is ignored. Reset mid-instruction aborts it with no partial writes afterwards.
//  Illegal state encodings -> FETCH.
// STRUCTURE
//  mips_pkg: state_t enum (4-bit), opcode localparams (R, LW, SW, ADDI, BEQ, J), alu_op and alu_src_b/pc_src encodings.
//  One sub-module: mc_ctrl_decode (combinational state_t -> output bundle). The top holds the state register and next-state logic.
// TESTING
//  add (op 000000), mem_ready=1 -> FETCH,DECODE,EXEC,ALUWB; reg_write=1, reg_dst=1 in cycle 4; instr_done at cycle 4.
//  lw (100011), mem_ready low for 2 cycles in MEMRD -> 7-cycle instruction; mem_to_reg=1, reg_write=1 only in MEMWB.
//  sw (101011), mem_ready=0 for 3 cycles in MEMWR -> mem_write held 4 cycles; reg_write never 1; done on release.
//  beq (000100) -> branch=1, alu_op=01, pc_src=01 on 3rd cycle; j (000010) -> pc_write=1, pc_src=10 on 3rd cycle.
//  Opcode 111111, ILLEGAL_TRAP=1 -> TRAP; illegal_instr=1 for 10+ cycles, zero strobes; rst_n=0 -> FETCH. With ILLEGAL_TRAP=0 -> FETCH after DECODE.
//  rst_n=0 during MEMWR -> next edge FETCH; mem_write=0 that cycle; MEM_HANDSHAKE=0 -> lw completes in 5 with mem_ready tied 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes and
// datapath select values, plus the control bundle the decoder produces.
package mips_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               branch;
    logic               iord;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               illegal_instr;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current control state (and memory ready for
// the handshake states) onto the datapath control bundle.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      // Write strobe stays up until memory accepts it; that cycle ends the sw.
      S_MEMWR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_B;
        o_ctrl.alu_op     = ALU_SUB;
        o_ctrl.pc_src     = PCSRC_ALUOUT;
        o_ctrl.branch     = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src     = PCSRC_JUMP;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_TRAP:  o_ctrl.illegal_instr = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: holds the state register and next-state logic;
// outputs are decoded from state and forced low while reset is asserted.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int unsigned OPCODE_W      = 6,
  parameter int unsigned ALU_OP_W      = 2,
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ILLEGAL_TRAP  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal_instr,
  output logic [3:0]          state_dbg
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  assign w_mem_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Opcode is only consulted in DECODE and MEMADR; elsewhere it is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) w_next = S_MEMADR;
        else if (opcode == OPCODE_W'(OP_R))    w_next = S_EXEC;
        else if (opcode == OPCODE_W'(OP_ADDI)) w_next = S_ADDIEX;
        else if (opcode == OPCODE_W'(OP_BEQ))  w_next = S_BRANCH;
        else if (opcode == OPCODE_W'(OP_J))    w_next = S_JUMP;
        else w_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
      end
      S_MEMADR: begin
        if (opcode == OPCODE_W'(OP_LW))      w_next = S_MEMRD;
        else if (opcode == OPCODE_W'(OP_SW)) w_next = S_MEMWR;
        else                                 w_next = S_FETCH;
      end
      S_MEMRD:  if (w_mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (w_mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (w_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign w_ctrl_out = rst_n ? w_ctrl : '0;

  assign pc_write      = w_ctrl_out.pc_write;
  assign branch        = w_ctrl_out.branch;
  assign iord          = w_ctrl_out.iord;
  assign mem_write     = w_ctrl_out.mem_write;
  assign ir_write      = w_ctrl_out.ir_write;
  assign reg_dst       = w_ctrl_out.reg_dst;
  assign mem_to_reg    = w_ctrl_out.mem_to_reg;
  assign reg_write     = w_ctrl_out.reg_write;
  assign alu_src_a     = w_ctrl_out.alu_src_a;
  assign alu_src_b     = w_ctrl_out.alu_src_b;
  assign pc_src        = w_ctrl_out.pc_src;
  assign alu_op        = ALU_OP_W'(w_ctrl_out.alu_op);
  assign instr_done    = w_ctrl_out.instr_done;
  assign illegal_instr = w_ctrl_out.illegal_instr;
  assign state_dbg     = rst_n ? 4'(r_state) : 4'h0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle vectors push expectations to a
// scoreboard that is drained and compared on each falling clock edge.
module tb_multicycle_control_unit;
  import mips_pkg::*;

  localparam logic [5:0] OP_ILL = 6'b111111;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    state_t     st;
  } vec_t;

  typedef struct {
    int     dut;
    int     idx;
    logic   rst;
    logic   rdy;
    state_t st;
  } sb_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_n_v = 3'b000;
  logic [5:0]  opcode = 6'b0;
  logic        mem_ready = 1'b1;
  logic [20:0] act [3];

  int   checks = 0;
  int   errors = 0;
  sb_t  sb [$];
  vec_t vt [$];

  always #5 clk = ~clk;

  // 0: default build, 1: ILLEGAL_TRAP=0, 2: MEM_HANDSHAKE=0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, br, iord, mw, irw, rdst, m2r, rw, sa, done, ill;
    logic [1:0] srcb, pcs, aop;
    logic [3:0] sdbg;
    multicycle_control_unit #(
      .OPCODE_W      (6),
      .ALU_OP_W      (2),
      .MEM_HANDSHAKE (g != 2),
      .ILLEGAL_TRAP  (g != 1)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n_v[g]),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pcw),
      .branch        (br),
      .iord          (iord),
      .mem_write     (mw),
      .ir_write      (irw),
      .reg_dst       (rdst),
      .mem_to_reg    (m2r),
      .reg_write     (rw),
      .alu_src_a     (sa),
      .alu_src_b     (srcb),
      .pc_src        (pcs),
      .alu_op        (aop),
      .instr_done    (done),
      .illegal_instr (ill),
      .state_dbg     (sdbg)
    );
    assign act[g] = {pcw, br, iord, mw, irw, rdst, m2r, rw, sa, srcb, pcs, aop, done, ill, sdbg};
  end

  // Expected outputs for a state, straight from the per-state output table.
  function automatic logic [20:0] exp_out(state_t st, logic rdy, logic rst);
    logic pcw, br, iord, mw, irw, rdst, m2r, rw, sa, done, ill;
    logic [1:0] srcb, pcs, aop;
    {pcw, br, iord, mw, irw, rdst, m2r, rw, sa, done, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    if (rst) begin
      case (st)
        S_FETCH:  begin srcb = 2'b01; irw = rdy; pcw = rdy; end
        S_DECODE: srcb = 2'b11;
        S_MEMADR: begin sa = 1'b1; srcb = 2'b10; end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB:  begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
        S_MEMWR:  begin iord = 1'b1; mw = 1'b1; done = rdy; end
        S_EXEC:   begin sa = 1'b1; aop = 2'b10; end
        S_ALUWB:  begin rdst = 1'b1; rw = 1'b1; done = 1'b1; end
        S_ADDIEX: begin sa = 1'b1; srcb = 2'b10; end
        S_ADDIWB: begin rw = 1'b1; done = 1'b1; end
        S_BRANCH: begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; done = 1'b1; end
        S_JUMP:   begin pcs = 2'b10; pcw = 1'b1; done = 1'b1; end
        S_TRAP:   ill = 1'b1;
        default:  ;
      endcase
    end
    return {pcw, br, iord, mw, irw, rdst, m2r, rw, sa, srcb, pcs, aop, done, ill,
            rst ? 4'(st) : 4'h0};
  endfunction

  sb_t         cur;
  logic [20:0] expv;
  logic [20:0] actv;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur  = sb.pop_front();
      expv = exp_out(cur.st, cur.rdy, cur.rst);
      actv = act[cur.dut];
      checks++;
      if (actv !== expv) begin
        errors++;
        $display("FAIL dut%0d step%0d: got %h, expected %h", cur.dut, cur.idx, actv, expv);
      end
    end
  end

  int step_idx = 0;

  // Drive one cycle on the chosen DUT (others held in reset) and queue its expectation.
  task automatic step(input int dut, input logic rst, input logic [5:0] op,
                      input logic rdy, input state_t st);
    sb_t it;
    logic [2:0] r;
    r = 3'b000;
    r[dut] = rst;
    rst_n_v   = r;
    opcode    = op;
    mem_ready = rdy;
    it.dut = dut;
    it.idx = step_idx;
    it.rst = rst;
    it.rdy = (dut == 2) ? 1'b1 : rdy;
    it.st  = st;
    sb.push_back(it);
    step_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic v(input logic rst, input logic [5:0] op, input logic rdy, input state_t st);
    vec_t e;
    e.rst = rst; e.op = op; e.rdy = rdy; e.st = st;
    vt.push_back(e);
  endtask

  initial begin
    // reset, then add
    v(0, OP_R, 1, S_FETCH);
    v(1, OP_R, 1, S_FETCH);  v(1, OP_R, 1, S_DECODE); v(1, OP_R, 1, S_EXEC); v(1, OP_R, 1, S_ALUWB);
    // lw with two stall cycles in MEMRD
    v(1, OP_LW, 1, S_FETCH); v(1, OP_LW, 1, S_DECODE); v(1, OP_LW, 1, S_MEMADR);
    v(1, OP_LW, 0, S_MEMRD); v(1, OP_LW, 0, S_MEMRD); v(1, OP_LW, 1, S_MEMRD); v(1, OP_LW, 1, S_MEMWB);
    // sw with three stall cycles in MEMWR
    v(1, OP_SW, 1, S_FETCH); v(1, OP_SW, 1, S_DECODE); v(1, OP_SW, 1, S_MEMADR);
    v(1, OP_SW, 0, S_MEMWR); v(1, OP_SW, 0, S_MEMWR); v(1, OP_SW, 0, S_MEMWR); v(1, OP_SW, 1, S_MEMWR);
    // beq with a fetch stall
    v(1, OP_BEQ, 0, S_FETCH); v(1, OP_BEQ, 1, S_FETCH); v(1, OP_BEQ, 1, S_DECODE); v(1, OP_BEQ, 1, S_BRANCH);
    v(1, OP_J, 1, S_FETCH);    v(1, OP_J, 1, S_DECODE);    v(1, OP_J, 1, S_JUMP);
    v(1, OP_ADDI, 1, S_FETCH); v(1, OP_ADDI, 1, S_DECODE); v(1, OP_ADDI, 1, S_ADDIEX); v(1, OP_ADDI, 1, S_ADDIWB);
    // opcode changes after DECODE must not redirect an R-type
    v(1, OP_R, 1, S_FETCH); v(1, OP_R, 1, S_DECODE); v(1, OP_LW, 1, S_EXEC); v(1, OP_SW, 1, S_ALUWB);
    // reset while a store is stalled in MEMWR
    v(1, OP_SW, 1, S_FETCH); v(1, OP_SW, 1, S_DECODE); v(1, OP_SW, 1, S_MEMADR);
    v(1, OP_SW, 0, S_MEMWR); v(0, OP_SW, 0, S_MEMWR); v(1, OP_SW, 0, S_FETCH);
    v(1, OP_J, 1, S_FETCH);  v(1, OP_J, 1, S_DECODE); v(1, OP_J, 1, S_JUMP);
    // illegal opcode traps until reset
    v(1, OP_ILL, 1, S_FETCH); v(1, OP_ILL, 1, S_DECODE);
    for (int i = 0; i < 10; i++)
      v(1, (i % 2 == 1) ? OP_R : OP_ILL, 1'(i % 2), S_TRAP);
    v(0, OP_R, 1, S_TRAP);
    v(1, OP_R, 1, S_FETCH); v(1, OP_R, 1, S_DECODE); v(1, OP_R, 1, S_EXEC); v(1, OP_R, 1, S_ALUWB);
    v(1, OP_R, 1, S_FETCH);

    @(posedge clk);
    #1;
    for (int i = 0; i < vt.size(); i++)
      step(0, vt[i].rst, vt[i].op, vt[i].rdy, vt[i].st);

    // ILLEGAL_TRAP=0: illegal opcode falls back to FETCH, next instruction runs
    step(1, 0, OP_ILL, 1, S_FETCH);
    step(1, 1, OP_ILL, 1, S_FETCH);
    step(1, 1, OP_ILL, 1, S_DECODE);
    step(1, 1, OP_R,   1, S_FETCH);
    step(1, 1, OP_R,   1, S_DECODE);
    step(1, 1, OP_R,   1, S_EXEC);
    step(1, 1, OP_R,   1, S_ALUWB);
    step(1, 1, OP_R,   1, S_FETCH);

    // MEM_HANDSHAKE=0: mem_ready tied low, lw still completes in 5, sw in 4
    step(2, 0, OP_LW, 0, S_FETCH);
    step(2, 1, OP_LW, 0, S_FETCH);
    step(2, 1, OP_LW, 0, S_DECODE);
    step(2, 1, OP_LW, 0, S_MEMADR);
    step(2, 1, OP_LW, 0, S_MEMRD);
    step(2, 1, OP_LW, 0, S_MEMWB);
    step(2, 1, OP_SW, 0, S_FETCH);
    step(2, 1, OP_SW, 0, S_DECODE);
    step(2, 1, OP_SW, 0, S_MEMADR);
    step(2, 1, OP_SW, 0, S_MEMWR);
    step(2, 1, OP_SW, 0, S_FETCH);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
